// File: rtl/tcam_req_pkg.sv
// Shared widths, opcode/state enums and the request payload for tcam_req_ctrl.
package tcam_req_pkg;

  localparam int unsigned ADDR_W = 28;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = 4;
  localparam int unsigned PMA_W  = 6;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned PERF_W = 32;

  typedef enum logic {
    OP_SEARCH = 1'b0,
    OP_WRITE  = 1'b1
  } tcam_op_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } tcam_state_e;

  typedef struct packed {
    tcam_op_e            op;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
    logic [MASK_W-1:0]   wmask;
  } tcam_req_t;

endpackage

// File: rtl/tcam_req_perf.sv
// Event counters for tcam_req_ctrl: search issues, write issues, response stalls.
module tcam_req_perf
  import tcam_req_pkg::*;
(
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              search_issue,
  input  logic              write_issue,
  input  logic              stall,
  output logic [PERF_W-1:0] perf_searches,
  output logic [PERF_W-1:0] perf_writes,
  output logic [PERF_W-1:0] perf_stall_cycles
);

  // Free-running wrap-around counters.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      perf_searches     <= '0;
      perf_writes       <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (search_issue) perf_searches     <= perf_searches + PERF_W'(1);
      if (write_issue)  perf_writes       <= perf_writes + PERF_W'(1);
      if (stall)        perf_stall_cycles <= perf_stall_cycles + PERF_W'(1);
    end
  end

endmodule

// File: rtl/tcam_req_ctrl.sv
// Request sequencer in front of the TCAM array: accepts one search/write,
// strobes the array for one cycle, waits a fixed latency, returns a response.
// Optional macro TCAM_REQ_CTRL_PERF_EN adds perf counter outputs.
module tcam_req_ctrl
  import tcam_req_pkg::*;
#(
  parameter int unsigned SEARCH_LAT = 2,
  parameter int unsigned WRITE_LAT  = 1
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [MASK_W-1:0] req_wmask,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_op,
  output logic [PMA_W-1:0]  resp_pma,
  output logic              tcam_csb,
  output logic              tcam_web,
  output logic [MASK_W-1:0] tcam_wmask,
  output logic [ADDR_W-1:0] tcam_addr,
  output logic [DATA_W-1:0] tcam_wdata,
  input  logic [PMA_W-1:0]  tcam_pma,
  output logic              busy
`ifdef TCAM_REQ_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_searches,
  output logic [PERF_W-1:0] perf_writes,
  output logic [PERF_W-1:0] perf_stall_cycles
`endif
);

  localparam logic [CNT_W-1:0] SEARCH_LOAD = CNT_W'(SEARCH_LAT - 1);
  localparam logic [CNT_W-1:0] WRITE_LOAD  = CNT_W'(WRITE_LAT - 1);

  tcam_state_e        state_q, state_d;
  tcam_req_t          req_q, req_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               csb_d, web_d, resp_valid_d, resp_op_d;
  logic [PMA_W-1:0]   resp_pma_d;

  // Array pins come straight from the captured request so they stay stable
  // through the wait window.
  assign tcam_addr  = req_q.addr;
  assign tcam_wdata = req_q.wdata;
  assign tcam_wmask = req_q.wmask;

  // State and output registers.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q    <= IDLE;
      req_q      <= '0;
      cnt_q      <= '0;
      tcam_csb   <= 1'b1;
      tcam_web   <= 1'b1;
      resp_valid <= 1'b0;
      resp_op    <= 1'b0;
      resp_pma   <= '0;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      cnt_q      <= cnt_d;
      tcam_csb   <= csb_d;
      tcam_web   <= web_d;
      resp_valid <= resp_valid_d;
      resp_op    <= resp_op_d;
      resp_pma   <= resp_pma_d;
      req_ready  <= (state_d == IDLE);
      busy       <= (state_d != IDLE);
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    cnt_d        = cnt_q;
    csb_d        = 1'b1;
    web_d        = tcam_web;
    resp_valid_d = resp_valid;
    resp_op_d    = resp_op;
    resp_pma_d   = resp_pma;
    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          req_d   = '{op: tcam_op_e'(req_op), addr: req_addr,
                      wdata: req_wdata, wmask: req_wmask};
          csb_d   = 1'b0;
          web_d   = ~req_op;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = (req_q.op == OP_WRITE) ? WRITE_LOAD : SEARCH_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          resp_pma_d   = (req_q.op == OP_WRITE) ? '0 : tcam_pma;
          resp_op_d    = req_q.op;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          web_d        = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef TCAM_REQ_CTRL_PERF_EN
  logic search_issue_c, write_issue_c, stall_c;

  assign search_issue_c = (state_q == ISSUE) && (req_q.op == OP_SEARCH);
  assign write_issue_c  = (state_q == ISSUE) && (req_q.op == OP_WRITE);
  assign stall_c        = (state_q == RESP) && !resp_ready;

  tcam_req_perf u_perf (
    .in_clk            (in_clk),
    .in_rst            (in_rst),
    .search_issue      (search_issue_c),
    .write_issue       (write_issue_c),
    .stall             (stall_c),
    .perf_searches     (perf_searches),
    .perf_writes       (perf_writes),
    .perf_stall_cycles (perf_stall_cycles)
  );
`endif

endmodule

// File: tb/tb_tcam_req_ctrl.sv
// Directed bench for tcam_req_ctrl; three instances cover SEARCH_LAT = 2, 1, 4.
module tb_tcam_req_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_op, resp_ready;
  logic [27:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wmask;
  logic [5:0]  tcam_pma;

  logic        req_ready, resp_valid, resp_op, tcam_csb, tcam_web, busy;
  logic [5:0]  resp_pma;
  logic [3:0]  tcam_wmask;
  logic [27:0] tcam_addr;
  logic [31:0] tcam_wdata;

  logic        req_ready_1, resp_valid_1, resp_op_1, tcam_csb_1, tcam_web_1, busy_1;
  logic [5:0]  resp_pma_1;
  logic [3:0]  tcam_wmask_1;
  logic [27:0] tcam_addr_1;
  logic [31:0] tcam_wdata_1;

  logic        req_ready_4, resp_valid_4, resp_op_4, tcam_csb_4, tcam_web_4, busy_4;
  logic [5:0]  resp_pma_4;
  logic [3:0]  tcam_wmask_4;
  logic [27:0] tcam_addr_4;
  logic [31:0] tcam_wdata_4;

`ifdef TCAM_REQ_CTRL_PERF_EN
  logic [31:0] perf_searches, perf_writes, perf_stall_cycles;
  logic [31:0] perf_searches_1, perf_writes_1, perf_stall_cycles_1;
  logic [31:0] perf_searches_4, perf_writes_4, perf_stall_cycles_4;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tcam_req_ctrl #(.SEARCH_LAT(2), .WRITE_LAT(1)) dut (
    .in_clk(clk), .in_rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_op(resp_op), .resp_pma(resp_pma),
    .tcam_csb(tcam_csb), .tcam_web(tcam_web), .tcam_wmask(tcam_wmask), .tcam_addr(tcam_addr),
    .tcam_wdata(tcam_wdata), .tcam_pma(tcam_pma), .busy(busy)
`ifdef TCAM_REQ_CTRL_PERF_EN
    , .perf_searches(perf_searches), .perf_writes(perf_writes),
    .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  tcam_req_ctrl #(.SEARCH_LAT(1), .WRITE_LAT(1)) dut1 (
    .in_clk(clk), .in_rst(rst), .req_valid(req_valid), .req_ready(req_ready_1),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid_1), .resp_ready(resp_ready), .resp_op(resp_op_1), .resp_pma(resp_pma_1),
    .tcam_csb(tcam_csb_1), .tcam_web(tcam_web_1), .tcam_wmask(tcam_wmask_1), .tcam_addr(tcam_addr_1),
    .tcam_wdata(tcam_wdata_1), .tcam_pma(tcam_pma), .busy(busy_1)
`ifdef TCAM_REQ_CTRL_PERF_EN
    , .perf_searches(perf_searches_1), .perf_writes(perf_writes_1),
    .perf_stall_cycles(perf_stall_cycles_1)
`endif
  );

  tcam_req_ctrl #(.SEARCH_LAT(4), .WRITE_LAT(1)) dut4 (
    .in_clk(clk), .in_rst(rst), .req_valid(req_valid), .req_ready(req_ready_4),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid_4), .resp_ready(resp_ready), .resp_op(resp_op_4), .resp_pma(resp_pma_4),
    .tcam_csb(tcam_csb_4), .tcam_web(tcam_web_4), .tcam_wmask(tcam_wmask_4), .tcam_addr(tcam_addr_4),
    .tcam_wdata(tcam_wdata_4), .tcam_pma(tcam_pma), .busy(busy_4)
`ifdef TCAM_REQ_CTRL_PERF_EN
    , .perf_searches(perf_searches_4), .perf_writes(perf_writes_4),
    .perf_stall_cycles(perf_stall_cycles_4)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

`ifdef TCAM_REQ_CTRL_PERF_EN
  // One full command on dut with a chosen number of back-pressure cycles in RESP.
  task automatic do_cmd(input logic op, input int stall_n);
    req_valid = 1'b1; req_op = op; req_addr = 28'h0000101; resp_ready = 1'b0;
    step();
    req_valid = 1'b0;
    for (int t = 0; t < 20 && !resp_valid; t++) step();
    chk("perf_resp_seen", 64'(resp_valid), 64'd1);
    for (int s = 0; s < stall_n; s++) step();
    resp_ready = 1'b1;
    step();
  endtask
`endif

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_addr = '0; req_wdata = '0;
    req_wmask = '0; resp_ready = 1'b1; tcam_pma = '0;
    step(); step();

    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_csb",       64'(tcam_csb),  64'd1);
    chk("rst_web",       64'(tcam_web),  64'd1);
    chk("rst_resp_valid",64'(resp_valid),64'd0);
    chk("rst_addr",      64'(tcam_addr), 64'd0);
    rst = 1'b0;
    step();

    // Search: accept, one strobe cycle, response 3 cycles after accept.
    req_valid = 1'b1; req_op = 1'b0; req_addr = 28'h0A1B2C3;
    req_wdata = 32'h11111111; req_wmask = 4'h3; tcam_pma = 6'h2A;
    step();
    req_valid = 1'b0;
    chk("srch_csb_issue",  64'(tcam_csb),  64'd0);
    chk("srch_web_issue",  64'(tcam_web),  64'd1);
    chk("srch_addr_issue", 64'(tcam_addr), 64'h0A1B2C3);
    chk("srch_req_ready",  64'(req_ready), 64'd0);
    chk("srch_busy",       64'(busy),      64'd1);
    step();
    chk("srch_csb_wait",   64'(tcam_csb),  64'd1);
    chk("srch_addr_wait",  64'(tcam_addr), 64'h0A1B2C3);
    chk("srch_rv_early1",  64'(resp_valid),64'd0);
    step();
    chk("srch_rv_early2",  64'(resp_valid),64'd0);
    step();
    chk("srch_rv",         64'(resp_valid),64'd1);
    chk("srch_pma",        64'(resp_pma),  64'h2A);
    chk("srch_op",         64'(resp_op),   64'd0);
    step();
    chk("srch_rv_drop",    64'(resp_valid),64'd0);
    chk("srch_ready_back", 64'(req_ready), 64'd1);

    // Write: strobe with web=0 and exact payload, response 2 cycles after accept.
    req_valid = 1'b1; req_op = 1'b1; req_addr = 28'h0000305;
    req_wdata = 32'hDEADBEEF; req_wmask = 4'hF; tcam_pma = 6'h15;
    step();
    req_valid = 1'b0;
    chk("wr_csb_issue",  64'(tcam_csb),   64'd0);
    chk("wr_web_issue",  64'(tcam_web),   64'd0);
    chk("wr_addr",       64'(tcam_addr),  64'h0000305);
    chk("wr_wdata",      64'(tcam_wdata), 64'hDEADBEEF);
    chk("wr_wmask",      64'(tcam_wmask), 64'hF);
    step();
    chk("wr_csb_wait",   64'(tcam_csb),   64'd1);
    chk("wr_rv_early",   64'(resp_valid), 64'd0);
    step();
    chk("wr_rv",         64'(resp_valid), 64'd1);
    chk("wr_pma",        64'(resp_pma),   64'd0);
    chk("wr_op",         64'(resp_op),    64'd1);
    step();

    // Back-pressure: a second search waits while the first response is held.
    resp_ready = 1'b0;
    req_valid = 1'b1; req_op = 1'b0; req_addr = 28'h1234567; tcam_pma = 6'h07;
    step();
    req_addr = 28'h7654321;
    step(); step(); step();
    chk("bp_rv", 64'(resp_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      tcam_pma = 6'(i + 40);
      step();
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      chk("bp_pma_hold",  64'(resp_pma),  64'h07);
      chk("bp_no_strobe", 64'(tcam_csb),  64'd1);
      chk("bp_rv_hold",   64'(resp_valid),64'd1);
    end
    resp_ready = 1'b1; tcam_pma = 6'h33;
    step();
    chk("bp_rv_drop",    64'(resp_valid), 64'd0);
    chk("bp_ready_back", 64'(req_ready),  64'd1);
    step();
    req_valid = 1'b0;
    chk("bp_new_strobe", 64'(tcam_csb),  64'd0);
    chk("bp_new_addr",   64'(tcam_addr), 64'h7654321);
    step(); step(); step();
    chk("bp_new_rv",     64'(resp_valid),64'd1);
    chk("bp_new_pma",    64'(resp_pma),  64'h33);
    step();

    // Reset held 3 cycles while in RESP discards the pending response.
    resp_ready = 1'b0; req_valid = 1'b1; req_op = 1'b0; req_addr = 28'h0000042;
    step();
    req_valid = 1'b0;
    step(); step(); step();
    chk("mr_rv_before", 64'(resp_valid), 64'd1);
    rst = 1'b1;
    step(); step(); step();
    rst = 1'b0;
    step();
    chk("mr_rv",        64'(resp_valid), 64'd0);
    chk("mr_csb",       64'(tcam_csb),   64'd1);
    chk("mr_req_ready", 64'(req_ready),  64'd1);
    chk("mr_busy",      64'(busy),       64'd0);

    // Stability: tcam_pma changes every cycle; value present at edge n after accept
    // is 5n+3, so LAT=1 samples n=2 (0x0D), LAT=2 n=3 (0x12), LAT=4 n=5 (0x1C).
    rst = 1'b1; step(); rst = 1'b0;
    resp_ready = 1'b0; req_valid = 1'b1; req_op = 1'b0; req_addr = 28'h0FFFFFF;
    step();
    req_valid = 1'b0;
    tcam_pma = 6'(1 * 5 + 3);
    for (int k = 1; k <= 7; k++) begin
      step();
      tcam_pma = 6'((k + 1) * 5 + 3);
    end
    chk("stab_rv_lat2", 64'(resp_valid),   64'd1);
    chk("stab_pma_lat2",64'(resp_pma),     64'h12);
    chk("stab_rv_lat1", 64'(resp_valid_1), 64'd1);
    chk("stab_pma_lat1",64'(resp_pma_1),   64'h0D);
    chk("stab_rv_lat4", 64'(resp_valid_4), 64'd1);
    chk("stab_pma_lat4",64'(resp_pma_4),   64'h1C);
    rst = 1'b1; step(); rst = 1'b0; resp_ready = 1'b1;
    step();

`ifdef TCAM_REQ_CTRL_PERF_EN
    // 5 searches, 3 writes, 4 stall cycles in total.
    do_cmd(1'b0, 1);
    do_cmd(1'b1, 0);
    do_cmd(1'b0, 2);
    do_cmd(1'b0, 0);
    do_cmd(1'b1, 0);
    do_cmd(1'b0, 1);
    do_cmd(1'b1, 0);
    do_cmd(1'b0, 0);
    chk("perf_searches", 64'(perf_searches),     64'd5);
    chk("perf_writes",   64'(perf_writes),       64'd3);
    chk("perf_stalls",   64'(perf_stall_cycles), 64'd4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
